// File: rtl/alu_op_sequencer.sv
// Registered request/response wrapper around a combinational 2-bit ALU.
// Optional divide-by-zero trap enabled by defining ALU_SEQ_DIV0_TRAP_EN.
module alu_op_sequencer #(
    parameter int unsigned DATA_W     = 2,
    parameter int unsigned RES_W      = 3,
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [1:0]        req_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_sel,
    input  logic [RES_W-1:0]  alu_out,
    input  logic              alu_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_result,
    output logic              rsp_carry,
    output logic              rsp_div0,
    output logic [7:0]        op_count
);

    localparam int unsigned OP_W  = 2;
    localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned OPC_W = 8;
    localparam logic [OP_W-1:0] OP_DIV = 2'b11;

    // Reject configurations the datapath cannot support.
    generate
        if (SETTLE_CYC == 0 || RES_W != DATA_W + 1) begin : g_cfg_check
            $error("alu_op_sequencer: SETTLE_CYC must be >= 1 and RES_W must equal DATA_W+1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    state_e              state_q,      state_d;
    logic [CNT_W-1:0]    settle_cnt_q, settle_cnt_d;
    logic [DATA_W-1:0]   alu_a_q,      alu_a_d;
    logic [DATA_W-1:0]   alu_b_q,      alu_b_d;
    logic [OP_W-1:0]     alu_sel_q,    alu_sel_d;
    logic                rsp_valid_q,  rsp_valid_d;
    logic [RES_W-1:0]    rsp_result_q, rsp_result_d;
    logic                rsp_carry_q,  rsp_carry_d;
    logic                rsp_div0_q,   rsp_div0_d;
    logic [OPC_W-1:0]    op_count_q,   op_count_d;
    logic                div0_hit;

    // Divide-by-zero detection on the operands currently held on the ALU.
    always_comb begin
        div0_hit = 1'b0;
`ifdef ALU_SEQ_DIV0_TRAP_EN
        div0_hit = (alu_sel_q == OP_DIV) && (alu_b_q == '0);
`endif
    end

    // Next-state and datapath update.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_div0_d   = rsp_div0_q;
        op_count_d   = op_count_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    alu_a_d      = req_a;
                    alu_b_d      = req_b;
                    alu_sel_d    = req_op;
                    settle_cnt_d = CNT_W'(SETTLE_CYC - 1);
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt_q == '0) begin
                    rsp_result_d = div0_hit ? '1 : alu_out;
                    rsp_carry_d  = alu_carry;
                    rsp_div0_d   = div0_hit;
                    rsp_valid_d  = 1'b1;
                    state_d      = HOLD;
                end else begin
                    settle_cnt_d = settle_cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + OPC_W'(1);
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_div0_q   <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_div0_q   <= rsp_div0_d;
            op_count_q   <= op_count_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_div0   = rsp_div0_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: one instance with SETTLE_CYC=1, one with SETTLE_CYC=4,
// each driving a behavioural 2-bit ALU.
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_DIV0_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    // Instance with SETTLE_CYC=1
    logic       rst_n, req_valid, req_ready, alu_carry, rsp_valid, rsp_ready, rsp_carry, rsp_div0;
    logic [1:0] req_a, req_b, req_op, alu_a, alu_b, alu_sel;
    logic [2:0] alu_out, rsp_result;
    logic [7:0] op_count;

    // Instance with SETTLE_CYC=4
    logic       rst_n4, req_valid4, req_ready4, alu_carry4, rsp_valid4, rsp_ready4, rsp_carry4, rsp_div04;
    logic [1:0] req_a4, req_b4, req_op4, alu_a4, alu_b4, alu_sel4;
    logic [2:0] alu_out4, rsp_result4;
    logic [7:0] op_count4;

    // Behavioural ALU: {carry of a+b, result}; divide by zero yields an arbitrary 3'b011.
    function automatic logic [3:0] alu_model(input logic [1:0] a, input logic [1:0] b,
                                             input logic [1:0] sel);
        logic [2:0] a3, b3, sum, res;
        a3  = {1'b0, a};
        b3  = {1'b0, b};
        sum = a3 + b3;
        case (sel)
            2'b00:   res = sum;
            2'b01:   res = a3 - b3;
            2'b10:   res = a3 * b3;
            default: res = (b3 == 3'd0) ? 3'b011 : a3 / b3;
        endcase
        return {sum[2], res};
    endfunction

    assign {alu_carry,  alu_out}  = alu_model(alu_a,  alu_b,  alu_sel);
    assign {alu_carry4, alu_out4} = alu_model(alu_a4, alu_b4, alu_sel4);

    alu_op_sequencer #(.DATA_W(2), .RES_W(3), .SETTLE_CYC(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_div0(rsp_div0), .op_count(op_count)
    );

    alu_op_sequencer #(.DATA_W(2), .RES_W(3), .SETTLE_CYC(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n4), .req_valid(req_valid4), .req_ready(req_ready4),
        .req_a(req_a4), .req_b(req_b4), .req_op(req_op4),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_sel(alu_sel4), .alu_out(alu_out4), .alu_carry(alu_carry4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_result(rsp_result4),
        .rsp_carry(rsp_carry4), .rsp_div0(rsp_div04), .op_count(op_count4)
    );

    // Reference arithmetic on plain integers.
    function automatic int ref_result(input int a, input int b, input int op);
        case (op)
            0:       return (a + b) % 8;
            1:       return (a - b + 8) % 8;
            2:       return (a * b) % 8;
            default: return (b == 0) ? (TRAP ? 7 : 3) : a / b;
        endcase
    endfunction

    function automatic int ref_carry(input int a, input int b);
        return (a + b > 3) ? 1 : 0;
    endfunction

    function automatic int ref_div0(input int b, input int op);
        return (TRAP && op == 3 && b == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
        int         res;
        int         carry;
        int         div0;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int   last_acc, n_acc, n_hs, t_acc, e_res, e_car, e_d0;
        bit   outst, e_valid;

        vecs[0] = '{2'd3, 2'd2, 2'd0, 5, 1, 0};
        vecs[1] = '{2'd1, 2'd2, 2'd1, 7, 0, 0};
        vecs[2] = '{2'd3, 2'd3, 2'd2, 1, 1, 0};
        vecs[3] = '{2'd2, 2'd0, 2'd3, TRAP ? 7 : 3, 0, TRAP ? 1 : 0};
        vecs[4] = '{2'd3, 2'd1, 2'd3, 3, 1, 0};
        vecs[5] = '{2'd2, 2'd3, 2'd1, 7, 1, 0};
        vecs[6] = '{2'd0, 2'd0, 2'd0, 0, 0, 0};
        vecs[7] = '{2'd3, 2'd2, 2'd3, 1, 1, 0};

        rst_n = 1'b0; req_valid = 1'b1; req_a = 2'd3; req_b = 2'd3; req_op = 2'd2; rsp_ready = 1'b1;
        rst_n4 = 1'b0; req_valid4 = 1'b0; req_a4 = '0; req_b4 = '0; req_op4 = '0; rsp_ready4 = 1'b0;
        step();
        step();
        chk("reset_req_ready", int'(req_ready), 1);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_result", int'(rsp_result), 0);
        chk("reset_rsp_carry", int'(rsp_carry), 0);
        chk("reset_rsp_div0", int'(rsp_div0), 0);
        chk("reset_op_count", int'(op_count), 0);
        chk("reset_alu_a", int'(alu_a), 0);
        chk("reset_alu_b", int'(alu_b), 0);
        chk("reset_alu_sel", int'(alu_sel), 0);
        chk("reset4_op_count", int'(op_count4), 0);
        req_valid = 1'b0; rsp_ready = 1'b0;
        rst_n = 1'b1; rst_n4 = 1'b1;
        step();

        // Table-driven single operations; odd entries assert rsp_ready early (must be ignored).
        for (int i = 0; i < 8; i++) begin
            chk("vec_ready_idle", int'(req_ready), 1);
            req_a = vecs[i].a; req_b = vecs[i].b; req_op = vecs[i].op; req_valid = 1'b1;
            step();
            req_valid = 1'b0;
            rsp_ready = (i % 2 == 1);
            chk("vec_settle_valid", int'(rsp_valid), 0);
            chk("vec_settle_ready", int'(req_ready), 0);
            chk("vec_alu_a", int'(alu_a), int'(vecs[i].a));
            chk("vec_alu_sel", int'(alu_sel), int'(vecs[i].op));
            step();
            chk("vec_rsp_valid", int'(rsp_valid), 1);
            chk("vec_result", int'(rsp_result), vecs[i].res);
            chk("vec_carry", int'(rsp_carry), vecs[i].carry);
            chk("vec_div0", int'(rsp_div0), vecs[i].div0);
            chk("vec_count_hold", int'(op_count), exp_cnt);
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            exp_cnt = (exp_cnt + 1) % 256;
            chk("vec_rsp_done", int'(rsp_valid), 0);
            chk("vec_count", int'(op_count), exp_cnt);
        end

        // Backpressure: response held while new requests are offered.
        req_a = 2'd1; req_b = 2'd1; req_op = 2'd2; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            req_valid = (i % 2 == 0); req_a = 2'd3; req_b = 2'd3; req_op = 2'd0;
            step();
            chk("bp_valid", int'(rsp_valid), 1);
            chk("bp_result", int'(rsp_result), 1);
            chk("bp_carry", int'(rsp_carry), 0);
            chk("bp_req_ready", int'(req_ready), 0);
            chk("bp_alu_a", int'(alu_a), 1);
            chk("bp_alu_sel", int'(alu_sel), 2);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % 256;
        chk("bp_release_valid", int'(rsp_valid), 0);
        chk("bp_release_ready", int'(req_ready), 1);
        chk("bp_release_count", int'(op_count), exp_cnt);

        // SETTLE_CYC=4: latency, then reset in the second settle cycle.
        req_a4 = 2'd1; req_b4 = 2'd2; req_op4 = 2'd0; req_valid4 = 1'b1;
        step();
        req_valid4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s4_latency_low", int'(rsp_valid4), 0);
        end
        step();
        chk("s4_latency_high", int'(rsp_valid4), 1);
        chk("s4_result", int'(rsp_result4), 3);
        chk("s4_carry", int'(rsp_carry4), 0);
        rsp_ready4 = 1'b1;
        step();
        rsp_ready4 = 1'b0;
        chk("s4_count", int'(op_count4), 1);
        req_a4 = 2'd3; req_b4 = 2'd3; req_op4 = 2'd0; req_valid4 = 1'b1;
        step();
        req_valid4 = 1'b0;
        step();
        rst_n4 = 1'b0;
        step();
        rst_n4 = 1'b1;
        chk("s4_rst_ready", int'(req_ready4), 1);
        chk("s4_rst_valid", int'(rsp_valid4), 0);
        chk("s4_rst_count", int'(op_count4), 0);
        chk("s4_rst_result", int'(rsp_result4), 0);
        rsp_ready4 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("s4_no_rsp", int'(rsp_valid4), 0);
        end
        rsp_ready4 = 1'b0;
        chk("s4_final_count", int'(op_count4), 0);

        // 256 back-to-back operations at the minimum request period.
        req_valid = 1'b1; rsp_ready = 1'b1;
        last_acc = 0; n_acc = 0; n_hs = 0;
        for (int i = 0; i < 768; i++) begin
            req_a = 2'($urandom_range(0, 3)); req_b = 2'($urandom_range(0, 3));
            req_op = 2'($urandom_range(0, 3));
            if (req_ready) begin
                if (n_acc > 0) chk("wrap_accept_gap", i - last_acc, 3);
                last_acc = i;
                n_acc++;
            end
            if (rsp_valid) n_hs++;
            step();
        end
        req_valid = 1'b0; rsp_ready = 1'b0;
        chk("wrap_accepts", n_acc, 256);
        chk("wrap_handshakes", n_hs, 256);
        chk("wrap_count", int'(op_count), exp_cnt);
        chk("wrap_idle", int'(req_ready), 1);

        // Random traffic against a transaction-level reference.
        outst = 1'b0; t_acc = 0; e_res = 0; e_car = 0; e_d0 = 0;
        for (int c = 0; c < 1500; c++) begin
            e_valid = outst && (c >= t_acc + 1);
            chk("rnd_req_ready", int'(req_ready), outst ? 0 : 1);
            chk("rnd_rsp_valid", int'(rsp_valid), e_valid ? 1 : 0);
            if (e_valid) begin
                chk("rnd_result", int'(rsp_result), e_res);
                chk("rnd_carry", int'(rsp_carry), e_car);
                chk("rnd_div0", int'(rsp_div0), e_d0);
            end
            chk("rnd_count", int'(op_count), exp_cnt);
            req_valid = 1'($urandom_range(0, 1));
            req_a = 2'($urandom_range(0, 3)); req_b = 2'($urandom_range(0, 3));
            req_op = 2'($urandom_range(0, 3));
            rsp_ready = 1'($urandom_range(0, 1));
            if (req_valid && !outst) begin
                outst = 1'b1;
                t_acc = c + 1;
                e_res = ref_result(int'(req_a), int'(req_b), int'(req_op));
                e_car = ref_carry(int'(req_a), int'(req_b));
                e_d0  = ref_div0(int'(req_b), int'(req_op));
            end else if (e_valid && rsp_ready) begin
                outst = 1'b0;
                exp_cnt = (exp_cnt + 1) % 256;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
